// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the cascadable multi-digit modulo counter.
// DIGIT_W    : width of every digit register (always 4 bits, whatever RADIX is)
// MAX_DIGITS : largest legal digit count per counter instance
// MAX_RADIX  : largest legal digit modulus
// clamp_digit: forces a preset digit into the legal range 0..radix-1
package bcd_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_RADIX  = 16;

  // A preset digit at or above the modulus becomes the largest legal digit,
  // so no load can ever put a digit outside 0..radix-1.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input int radix);
    if (int'(d) >= radix) return DIGIT_W'(radix - 1);
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One modulo-RADIX digit of the counter.
// Ports:
//   CLK   in  clock, rising edge
//   CLR   in  synchronous active-high clear (highest priority)
//   LOAD  in  synchronous load of pre (clamped to RADIX-1)
//   pre   in  4-bit preset digit
//   en    in  count this digit on the edge (already qualified by lower digits)
//   UP    in  1 = increment, 0 = decrement
//   q     out current digit value
//   tc_up out digit is at RADIX-1
//   tc_dn out digit is at 0
module bcd_digit_cell
  import bcd_counter_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] pre,
  input  logic               en,
  input  logic               UP,
  output logic [DIGIT_W-1:0] q,
  output logic               tc_up,
  output logic               tc_dn
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD) begin
      q_d = clamp_digit(pre, RADIX);
    end else if (en) begin
      if (UP) q_d = (q_q == TOP)   ? '0  : q_q + DIGIT_W'(1);
      else    q_d = (q_q == '0)    ? TOP : q_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q     = q_q;
  assign tc_up = (q_q == TOP);
  assign tc_dn = (q_q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit up/down modulo counter with synchronous load,
// ripple carry/borrow output and a sticky wrap flag.
// Ports:
//   CLK  in  clock, rising edge
//   CLR  in  synchronous active-high clear of Q and OVF
//   ENP  in  parallel count enable
//   ENT  in  trickle count enable, also gates RCO
//   LOAD in  synchronous load of PRE (digits clamped to RADIX-1), clears OVF
//   UP   in  1 = count up, 0 = count down
//   PRE  in  preset, digit i in bits [4i+3:4i]
//   Q    out counter value, same packing as PRE
//   RCO  out ENT && terminal state for the current direction (combinational)
//   OVF  out sticky full-wrap flag, cleared by CLR or LOAD
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic                      LOAD,
  input  logic                      UP,
  input  logic [DIGIT_W*DIGITS-1:0] PRE,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      RCO,
  output logic                      OVF
);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || RADIX < 2 || RADIX > MAX_RADIX) begin : g_bad_param
    $fatal(1, "bcd_updown_counter: illegal DIGITS=%0d or RADIX=%0d", DIGITS, RADIX);
  end

  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] tc_up;
  logic [DIGITS-1:0] tc_dn;
  logic [DIGITS-1:0] tc_dir;
  logic              count_en;
  logic              tc;
  logic              ovf_q;
  logic              ovf_d;

  assign count_en = ENP && ENT;
  assign tc_dir   = UP ? tc_up : tc_dn;

  // A digit moves only when every lower digit is at its terminal value
  // for the current direction.
  assign en[0] = count_en;
  for (genvar i = 1; i < DIGITS; i++) begin : g_chain
    assign en[i] = en[i-1] && tc_dir[i-1];
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .RADIX (RADIX)
    ) u_cell (
      .CLK   (CLK),
      .CLR   (CLR),
      .LOAD  (LOAD),
      .pre   (PRE[DIGIT_W*i +: DIGIT_W]),
      .en    (en[i]),
      .UP    (UP),
      .q     (Q[DIGIT_W*i +: DIGIT_W]),
      .tc_up (tc_up[i]),
      .tc_dn (tc_dn[i])
    );
  end

  assign tc  = &tc_dir;
  assign RCO = ENT && tc;

  // A counting edge taken from the terminal state is a full wrap.
  always_comb begin
    ovf_d = ovf_q;
    if (LOAD)                 ovf_d = 1'b0;
    else if (count_en && tc)  ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic       clk;
  logic       clr, load, enp, ent, up;
  logic [7:0] pre;
  logic [7:0] q;
  logic       rco, ovf;

  logic       c_clr, c_load, c_enp, c_ent, c_up;
  logic [7:0] c_pre_lo, c_pre_hi;
  logic [7:0] q_lo, q_hi;
  logic       rco_lo, rco_hi, ovf_lo, ovf_hi;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) dut (
    .CLK(clk), .CLR(clr), .ENP(enp), .ENT(ent), .LOAD(load), .UP(up),
    .PRE(pre), .Q(q), .RCO(rco), .OVF(ovf)
  );

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) u_lo (
    .CLK(clk), .CLR(c_clr), .ENP(c_enp), .ENT(c_ent), .LOAD(c_load), .UP(c_up),
    .PRE(c_pre_lo), .Q(q_lo), .RCO(rco_lo), .OVF(ovf_lo)
  );

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) u_hi (
    .CLK(clk), .CLR(c_clr), .ENP(c_enp), .ENT(rco_lo), .LOAD(c_load), .UP(c_up),
    .PRE(c_pre_hi), .Q(q_hi), .RCO(rco_hi), .OVF(ovf_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       clr, load, enp, ent, up;
    logic [7:0] pre;
    logic [7:0] q;
    logic       ovf, rco;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic c, l, p, t, u, input logic [7:0] pr,
                         input logic [7:0] eq, input logic eo, er);
    vec_t v;
    v.clr = c; v.load = l; v.enp = p; v.ent = t; v.up = u; v.pre = pr;
    v.q = eq; v.ovf = eo; v.rco = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the counter value as a plain integer 0..99.
  localparam int MAXV = 99;
  int mval;
  bit movf;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int pre_val(input logic [7:0] p);
    int hi, lo;
    hi = int'(p[7:4]); lo = int'(p[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic model_edge(input logic c, l, p, t, u, input logic [7:0] pr);
    if (c) begin
      mval = 0; movf = 0;
    end else if (l) begin
      mval = pre_val(pr); movf = 0;
    end else if (p && t) begin
      if (u) begin
        if (mval == MAXV) begin mval = 0; movf = 1; end
        else mval = mval + 1;
      end else begin
        if (mval == 0) begin mval = MAXV; movf = 1; end
        else mval = mval - 1;
      end
    end
  endtask

  initial begin
    clr = 1; load = 0; enp = 1; ent = 1; up = 1; pre = 8'h00;
    c_clr = 1; c_load = 0; c_enp = 0; c_ent = 1; c_up = 1;
    c_pre_lo = 8'h00; c_pre_hi = 8'h00;

    // reset, then 10 counts up
    add_vec(1, 0, 1, 1, 1, 8'h00, 8'h00, 0, 0);
    for (int n = 1; n <= 10; n++) add_vec(0, 0, 1, 1, 1, 8'h00, to_bcd(n), 0, 0);
    // up wrap, OVF sticky through hold
    add_vec(0, 1, 1, 1, 1, 8'h98, 8'h98, 0, 0);
    add_vec(0, 0, 1, 1, 1, 8'h00, 8'h99, 0, 1);
    add_vec(0, 0, 1, 1, 1, 8'h00, 8'h00, 1, 0);
    add_vec(0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 0);
    // down and borrow
    add_vec(0, 1, 1, 1, 0, 8'h01, 8'h01, 0, 0);
    add_vec(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1);
    add_vec(0, 0, 1, 1, 0, 8'h00, 8'h99, 1, 0);
    add_vec(0, 1, 0, 1, 0, 8'h05, 8'h05, 0, 0);
    // clamp and priority
    add_vec(0, 1, 0, 0, 1, 8'hFC, 8'h99, 0, 0);
    add_vec(1, 1, 1, 1, 1, 8'h37, 8'h00, 0, 0);
    add_vec(0, 1, 1, 1, 1, 8'h42, 8'h42, 0, 0);
    // wrap and load on the same edge: no OVF
    add_vec(0, 1, 0, 1, 1, 8'h99, 8'h99, 0, 1);
    add_vec(0, 1, 1, 1, 1, 8'h12, 8'h12, 0, 0);
    // enables at 0x99
    add_vec(0, 1, 0, 1, 1, 8'h99, 8'h99, 0, 1);
    add_vec(0, 0, 0, 1, 1, 8'h00, 8'h99, 0, 1);
    add_vec(0, 0, 1, 0, 1, 8'h00, 8'h99, 0, 0);
    // direction flip around 0x50
    add_vec(0, 1, 0, 1, 1, 8'h50, 8'h50, 0, 0);
    add_vec(0, 0, 1, 1, 1, 8'h00, 8'h51, 0, 0);
    add_vec(0, 0, 1, 1, 0, 8'h00, 8'h50, 0, 0);
    add_vec(0, 0, 1, 1, 1, 8'h00, 8'h51, 0, 0);
    add_vec(0, 0, 1, 1, 0, 8'h00, 8'h50, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; load = vecs[i].load; enp = vecs[i].enp;
      ent = vecs[i].ent; up = vecs[i].up; pre = vecs[i].pre;
      @(posedge clk); #1;
      if (i == 0) c_clr = 0;
      check($sformatf("vec%0d q", i),   32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d rco", i), 32'(rco), 32'(vecs[i].rco));
    end

    // CLR pulse between edges changes nothing
    clr = 0; load = 0; enp = 0; ent = 0;
    clr = 1; #3; clr = 0; #2;
    check("clr_between_edges q", 32'(q), 32'h50);
    @(posedge clk); #1;
    check("clr_between_edges after edge q", 32'(q), 32'h50);

    // two-stage cascade: 0x9999 -> 0x0000 in one edge
    c_load = 1; c_pre_lo = 8'h99; c_pre_hi = 8'h99; c_enp = 0; c_ent = 1; c_up = 1;
    @(posedge clk); #1;
    c_load = 0;
    #1;
    check("chain loaded lo", 32'(q_lo), 32'h99);
    check("chain loaded hi", 32'(q_hi), 32'h99);
    check("chain rco_hi at 9999", 32'(rco_hi), 32'h1);
    c_enp = 1;
    @(posedge clk); #1;
    c_enp = 0;
    check("chain wrap lo", 32'(q_lo), 32'h00);
    check("chain wrap hi", 32'(q_hi), 32'h00);
    check("chain wrap ovf_hi", 32'(ovf_hi), 32'h1);
    check("chain wrap rco_hi", 32'(rco_hi), 32'h0);
    // carry from low stage into high stage
    c_load = 1; c_pre_lo = 8'h99; c_pre_hi = 8'h05;
    @(posedge clk); #1;
    c_load = 0; c_enp = 1;
    @(posedge clk); #1;
    c_enp = 0;
    check("chain carry lo", 32'(q_lo), 32'h00);
    check("chain carry hi", 32'(q_hi), 32'h06);
    check("chain carry ovf_hi", 32'(ovf_hi), 32'h0);

    // randomized run against the integer model
    mval = 0; movf = 0; up = 1;
    for (int k = 0; k < 400; k++) begin
      clr  = (k == 0) || ($urandom_range(31) == 0);
      load = ($urandom_range(15) == 0);
      enp  = ($urandom_range(3) != 0);
      ent  = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) up = ~up;
      pre  = 8'($urandom);
      #1;
      if (k != 0)
        check($sformatf("rand%0d rco", k), 32'(rco),
              32'(ent && (up ? (mval == MAXV) : (mval == 0))));
      model_edge(clr, load, enp, ent, up, pre);
      @(posedge clk); #1;
      check($sformatf("rand%0d q", k),   32'(q),   32'(to_bcd(mval)));
      check($sformatf("rand%0d ovf", k), 32'(ovf), 32'(movf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised, synchronous, cascadable multi-digit modulo counter: the successor of the team's single-digit decade counter. It generalises digit count and radix, adds up/down counting, a dedicated synchronous load, a ripple-carry output for chaining, and a sticky wrap flag. It drives display and timing chains in the lab designs and is chained through its enable and carry pins.

## Interface
Parameters:
- DIGITS, 2: number of cascaded digits (1..8).
- RADIX, 10: modulus of each digit (2..16). Each digit is always 4 bits wide.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  synchronous, active-high reset: clears Q and OVF on the next CLK edge.
- ENP  in  1  count enable (parallel).
- ENT  in  1  count enable (trickle); also gates RCO.
- LOAD  in  1  synchronous active-high load of PRE.
- UP  in  1  direction: 1 = count up, 0 = count down.
- PRE  in  4*DIGITS  preset value; digit i is bits [4i+3:4i], digit 0 least significant.
- Q  out  4*DIGITS  counter value, same digit packing as PRE.
- RCO  out  1  ripple carry/borrow out, combinational.
- OVF  out  1  sticky wrap flag, registered.

## Operation
- Priority per edge: CLR > LOAD > count (ENP && ENT) > hold.
- CLR: Q = 0 and OVF = 0. CLR has effect only on a CLK edge; an asserted CLR between edges changes nothing.
- LOAD: each digit takes its PRE digit, clamped to RADIX-1 if it is ≥ RADIX. OVF is cleared. LOAD ignores ENP, ENT and UP.
- Count up: digit 0 increments. A digit at RADIX-1 goes to 0 and carries into the next digit; the next digit increments only when all lower digits are at RADIX-1.
- Count down: symmetric. A digit at 0 goes to RADIX-1 and borrows; the next digit decrements only when all lower digits are 0.
- Full wrap:
  - Up: all digits RADIX-1 → all 0.
  - Down: all digits 0 → all RADIX-1.
  - On the same edge OVF is set to 1 and stays set until CLR or LOAD.
- Terminal state TC is "all digits RADIX-1" when UP = 1, or "all digits 0" when UP = 0.
  - RCO = ENT && TC. It is independent of ENP, matching the 161-style cascade rule.
- Cascading: stage n+1 has ENT tied to RCO of stage n, and both stages share ENP.
- Hold (ENP = 0 or ENT = 0, no LOAD/CLR): Q and OVF are unchanged.
- Changing UP mid-count takes effect on the next counting edge; no state is lost.
- Digits can never reach the range ≥ RADIX after any reset or load.

## Timing
- Q and OVF are registered: updated one CLK edge after the qualifying inputs are sampled, and visible in the same cycle after the edge.
- RCO is combinational from Q, UP and ENT, with zero-cycle latency. It has no path from ENP, LOAD, CLR or PRE.
- CLR, LOAD, ENP, ENT and UP are sampled at the rising edge only. There are no asynchronous paths.
- Reset values (after the first edge with CLR = 1): Q = 0, OVF = 0, RCO = ENT && !UP.
- Simultaneous events:
  - CLR + LOAD: CLR wins.
  - LOAD + count: LOAD wins and OVF clears.
  - Wrap + LOAD on the same edge: no OVF set.
- CLR asserted mid-count: the next edge gives Q = 0 regardless of the carry in flight.

## Structure
- Package bcd_counter_pkg holds:
  - DIGIT_W = 4.
  - Limits MAX_DIGITS = 8 and MAX_RADIX = 16.
  - A function for the clamp-to-RADIX-1 rule.
- Sub-module bcd_digit_cell: one 4-bit digit register with RADIX parameter.
  - Inputs: CLK, CLR, LOAD, pre, en, UP.
  - Outputs: q, tc_up (= RADIX-1), tc_dn (= 0).
- Top level:
  - Generates DIGITS cells.
  - Builds the enable chain en[i] = ENP && ENT && all lower cells at their terminal for the current UP.
  - Forms RCO and holds the OVF register.
- Elaboration check: an illegal DIGITS or RADIX raises a fatal error.

## Test plan
All scenarios use DIGITS = 2, RADIX = 10.
- Reset: CLR = 1 for 1 edge with ENP = ENT = UP = 1 → Q = 0x00, OVF = 0, RCO = 0. Then count 10 edges → Q = 0x10.
- Up wrap: LOAD PRE = 0x98, then count 2 edges up → Q = 0x99 with RCO = 1, then Q = 0x00 with OVF = 1 and RCO = 0.
- Down and borrow: LOAD 0x01, UP = 0, count 2 edges → Q = 0x00 with RCO = 1, then 0x99 with OVF = 1. Then LOAD 0x05 → OVF = 0.
- Clamp and priority:
  - LOAD PRE = 0xFC → Q = 0x99.
  - CLR + LOAD on the same edge → Q = 0x00.
  - LOAD + ENP/ENT on the same edge → Q = PRE.
- Enables:
  - ENP = 0, ENT = 1 at Q = 0x99 (UP = 1) → Q holds and RCO = 1.
  - ENT = 0 → Q holds and RCO = 0.
  - Two instances chained by RCO→ENT count 0x9999 → 0x0000 in one edge.
- Direction flip: at Q = 0x50 toggle UP every edge for 4 edges → 0x51, 0x50, 0x51, 0x50. OVF stays 0.
